// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-stage instruction memory model.
// Holds the response payload layout and the address legality rule.
package fetch_pkg;

   localparam int IMEM_DATA_W = 32;
   localparam int IMEM_ADDR_W = 32;

   // Returned in place of ROM content for any illegal fetch address.
   localparam logic [IMEM_DATA_W-1:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [IMEM_DATA_W-1:0] data;
      logic                   err;
   } imem_rsp_t;

   // Legal iff word aligned and the word index falls inside the ROM.
   function automatic logic imem_addr_ok(input logic [IMEM_ADDR_W-1:0] addr,
                                         input int unsigned            depth);
      logic [IMEM_ADDR_W-1:0] word_idx;
      word_idx = addr >> 2;
      return (addr[1:0] == 2'b00) && (word_idx < IMEM_ADDR_W'(depth));
   endfunction

endpackage

// File: rtl/fetch_imem_rsp_fifo.sv
// Synchronous response FIFO with a one-cycle flush.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module fetch_imem_rsp_fifo #(
   parameter int  WIDTH = 33,
   parameter int  DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [PTR_W-1:0] count
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [IDX_W-1:0] wr_idx;
   logic [IDX_W-1:0] rd_idx;
   logic             do_push;
   logic             do_pop;

   assign count  = wr_ptr - rd_ptr;
   assign empty  = (wr_ptr == rd_ptr);
   assign full   = (count == PTR_W'(DEPTH));
   assign wr_idx = (DEPTH > 1) ? wr_ptr[IDX_W-1:0] : '0;
   assign rd_idx = (DEPTH > 1) ? rd_ptr[IDX_W-1:0] : '0;

   // A push into a full FIFO is only legal when the head leaves in the same cycle.
   assign do_pop  = pop && !empty && !flush;
   assign do_push = push && !flush && (!full || do_pop);

   assign rdata = mem[rd_idx];

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
   end

   // NOTE: storage is not reset; the pointers alone define which entries are meaningful.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_idx] <= wdata;
   end

endmodule

// File: rtl/fetch_imem_model.sv
// Instruction ROM behind a valid/ready fetch handshake with fixed read latency,
// credit-limited acceptance so the response FIFO can never overflow, and flush.
module fetch_imem_model
  import fetch_pkg::*;
#(
  parameter int    DATA_W    = 32,
  parameter int    ADDR_W    = 32,
  parameter int    DEPTH     = 64,
  parameter int    LATENCY   = 1,
  parameter int    RSP_DEPTH = 4,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] addr_in,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rsp_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(RSP_DEPTH) + 1;
  localparam int RSP_W = $bits(imem_rsp_t);

  logic [IDX_W-1:0]  rom_idx;
  logic [DATA_W-1:0] rom_word;
  logic [DATA_W-1:0] rom [DEPTH];
  logic              addr_ok;
  imem_rsp_t         lookup_rsp;

  logic              run_q;
  logic              req_fire;
  logic              push_valid;
  imem_rsp_t         push_rsp;
  imem_rsp_t         head_rsp;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  pipe_count;
  logic [CNT_W-1:0]  inflight;

  assign rom_idx = addr_in[IDX_W+1:2];

  // Built-in image: word i holds i+1.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
    assign rom[gi] = DATA_W'(gi) + DATA_W'(1);
  end

  assign rom_word = rom[rom_idx];

  // Illegal addresses never expose ROM content, even if the index bits alias a real word.
  always_comb begin
    addr_ok         = imem_addr_ok(IMEM_ADDR_W'(addr_in), DEPTH);
    lookup_rsp.err  = !addr_ok;
    lookup_rsp.data = addr_ok ? IMEM_DATA_W'(rom_word) : NOP_INSTR;
  end

  // Each accepted request holds one credit until its response is consumed.
  assign inflight  = pipe_count + fifo_count;
  assign req_ready = run_q && !flush && (inflight < CNT_W'(RSP_DEPTH));
  assign req_fire  = req_valid && req_ready;
  assign fifo_pop  = rsp_valid && rsp_ready && !flush;
  assign fifo_push = push_valid && !flush && (!fifo_full || fifo_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  // The accepted request is stage 0; LATENCY-1 registered stages follow before the FIFO.
  if (LATENCY == 1) begin : g_no_pipe
    assign push_valid = req_fire;
    assign push_rsp   = lookup_rsp;
    assign pipe_count = '0;
  end else begin : g_pipe
    logic [LATENCY-2:0] pipe_valid;
    imem_rsp_t          pipe_rsp [LATENCY-1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pipe_valid <= '0;
      end else if (flush) begin
        pipe_valid <= '0;
      end else begin
        pipe_valid[0] <= req_fire;
        for (int i = 1; i < LATENCY-1; i++) pipe_valid[i] <= pipe_valid[i-1];
      end
    end

    always_ff @(posedge clk) begin
      pipe_rsp[0] <= lookup_rsp;
      for (int i = 1; i < LATENCY-1; i++) pipe_rsp[i] <= pipe_rsp[i-1];
    end

    // NOTE: combinational outputs get a default first so no path can infer a latch.
    always_comb begin
      pipe_count = '0;
      for (int i = 0; i < LATENCY-1; i++) pipe_count = pipe_count + CNT_W'(pipe_valid[i]);
    end

    assign push_valid = pipe_valid[LATENCY-2];
    assign push_rsp   = pipe_rsp[LATENCY-2];
  end

  fetch_imem_rsp_fifo #(
    .WIDTH (RSP_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (fifo_push),
    .wdata (push_rsp),
    .pop   (fifo_pop),
    .rdata (head_rsp),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Outputs read zero whenever nothing is queued, matching the reset values.
  assign rsp_valid = !fifo_empty;
  assign rdata     = rsp_valid ? DATA_W'(head_rsp.data) : '0;
  assign rsp_err   = rsp_valid && head_rsp.err;

endmodule
